// File: rtl/prog_rom_loader.sv
// Program ROM with run-time loader: serves fetch reads and rewrites
// its contents from a length-prefixed little-endian byte stream.
module prog_rom_loader #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic [31:0]       instruction_o,
  input  logic              upg_start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o,
  output logic [LEN_W-1:0]  words_written_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [1:0]        cnt_q;
  logic [23:0]       word_q;
  logic [31:0]       mem_q [DEPTH];

  logic              in_range;
  logic              last_byte;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic [LEN_W-1:0]  words_d;
  logic [LEN_W-1:0]  len_d;

  // Words past the end of memory are counted but dropped.
  assign in_range  = (words_written_o >> ADDR_W) == '0;
  assign last_byte = (state_q == S_DATA) && byte_valid_i
                     && (cnt_q == 2'd3);
  assign we        = last_byte && in_range;
  assign waddr     = ADDR_W'(words_written_o);
  assign wdata     = {byte_data_i, word_q};
  assign words_d   = (&words_written_o) ? words_written_o
                     : words_written_o + LEN_W'(1);
  assign len_d     = LEN_W'({byte_data_i, len_q[7:0]});

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      len_q           <= '0;
      cnt_q           <= '0;
      word_q          <= '0;
      cpu_hold_o      <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      words_written_o <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (upg_start_i) begin
            state_q         <= S_LEN0;
            cpu_hold_o      <= 1'b1;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
            words_written_o <= '0;
            cnt_q           <= '0;
          end
        end
        S_LEN0: begin
          if (byte_valid_i) begin
            len_q   <= LEN_W'(byte_data_i);
            state_q <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (byte_valid_i) begin
            len_q   <= len_d;
            state_q <= (len_d == '0) ? S_DONE : S_DATA;
          end
        end
        S_DATA: begin
          if (byte_valid_i) begin
            cnt_q  <= cnt_q + 2'd1;
            word_q <= {byte_data_i, word_q[23:8]};
            if (cnt_q == 2'd3) begin
              words_written_o <= words_d;
              if (!in_range) err_o <= 1'b1;
              if (words_d == len_q) state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_o     <= 1'b1;
          cpu_hold_o <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Separate from the write so a same-address read returns old data.
  always_ff @(posedge clock) begin
    if (reset) instruction_o <= '0;
    else       instruction_o <= mem_q[fetch_addr_i];
  end

endmodule

// File: tb/tb_prog_rom_loader.sv
// Directed bench for prog_rom_loader: a default-size instance and a
// 4-word instance share stimulus; each task checks its own results.
module tb_prog_rom_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] fa;
  logic        upg;
  logic        bv;
  logic [7:0]  bd;

  logic [31:0] i0, i2;
  logic        h0, d0, e0, h2, d2, e2;
  logic [15:0] w0, w2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prog_rom_loader #(.ADDR_W(14), .LEN_W(16)) dut0 (
    .clock(clk), .reset(rst), .fetch_addr_i(fa),
    .instruction_o(i0), .upg_start_i(upg),
    .byte_valid_i(bv), .byte_data_i(bd),
    .cpu_hold_o(h0), .done_o(d0), .err_o(e0),
    .words_written_o(w0)
  );

  prog_rom_loader #(.ADDR_W(2), .LEN_W(16)) dut2 (
    .clock(clk), .reset(rst), .fetch_addr_i(fa[1:0]),
    .instruction_o(i2), .upg_start_i(upg),
    .byte_valid_i(bv), .byte_data_i(bd),
    .cpu_hold_o(h2), .done_o(d2), .err_o(e2),
    .words_written_o(w2)
  );

  task automatic put(input logic [7:0] b);
    bv = 1'b1;
    bd = b;
    @(negedge clk);
    bv = 1'b0;
  endtask

  task automatic start();
    upg = 1'b1;
    @(negedge clk);
    upg = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fa = '0; upg = 1'b0; bv = 1'b0; bd = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (i0 !== 32'h0) begin
      failures++; $display("FAIL rst_instr got=%h exp=0", i0);
    end
    checks++;
    if ({h0, d0, e0} !== 3'b000) begin
      failures++; $display("FAIL rst_flags got=%b exp=000", {h0, d0, e0});
    end
    checks++;
    if (w0 !== 16'd0) begin
      failures++; $display("FAIL rst_words got=%0d exp=0", w0);
    end
    rst = 1'b0;
  endtask

  task automatic test_program();
    logic [7:0] s [10] = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD,
                           8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    start();
    checks++;
    if (h0 !== 1'b1 || w0 !== 16'd0) begin
      failures++; $display("FAIL prog_start got=%b/%0d exp=1/0", h0, w0);
    end
    foreach (s[i]) put(s[i]);
    checks++;
    if (h0 !== 1'b1 || w0 !== 16'd2 || d0 !== 1'b0) begin
      failures++;
      $display("FAIL prog_last got=%b/%0d/%b exp=1/2/0", h0, w0, d0);
    end
    @(negedge clk);
    checks++;
    if ({h0, d0, e0} !== 3'b010) begin
      failures++; $display("FAIL prog_done got=%b exp=010", {h0, d0, e0});
    end
    fa = 14'd0;
    @(negedge clk);
    checks++;
    if (i0 !== 32'hDEADBEEF) begin
      failures++; $display("FAIL prog_m0 got=%h exp=deadbeef", i0);
    end
    fa = 14'd1;
    @(negedge clk);
    checks++;
    if (i0 !== 32'h12345678) begin
      failures++; $display("FAIL prog_m1 got=%h exp=12345678", i0);
    end
  endtask

  task automatic test_fetch_after_reset();
    logic [7:0]  s [18] = '{8'h04, 8'h00,
                           8'h93, 8'h00, 8'h50, 8'h00,
                           8'h13, 8'h01, 8'hA0, 8'h00,
                           8'hB3, 8'h81, 8'h20, 8'h00,
                           8'h6F, 8'h00, 8'h00, 8'h00};
    logic [31:0] img [4] = '{32'h00500093, 32'h00A00113,
                             32'h002081B3, 32'h0000006F};
    start();
    foreach (s[i]) put(s[i]);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (h0 !== 1'b0 || d0 !== 1'b0) begin
      failures++; $display("FAIL fr_flags got=%b%b exp=00", h0, d0);
    end
    for (int a = 0; a < 4; a++) begin
      fa = 14'(a);
      @(negedge clk);
      checks++;
      if (i0 !== img[a]) begin
        failures++; $display("FAIL fr_m%0d got=%h exp=%h", a, i0, img[a]);
      end
    end
  endtask

  task automatic test_zero_len();
    upg = 1'b1; bv = 1'b1; bd = 8'h07;
    @(negedge clk);
    upg = 1'b0; bv = 1'b0;
    put(8'h00);
    put(8'h00);
    checks++;
    if (h0 !== 1'b1 || d0 !== 1'b0) begin
      failures++; $display("FAIL zl_len1 got=%b%b exp=10", h0, d0);
    end
    @(negedge clk);
    checks++;
    if (h0 !== 1'b0 || d0 !== 1'b1 || w0 !== 16'd0) begin
      failures++;
      $display("FAIL zl_done got=%b%b/%0d exp=01/0", h0, d0, w0);
    end
    fa = 14'd0;
    @(negedge clk);
    checks++;
    if (i0 !== 32'h00500093) begin
      failures++; $display("FAIL zl_nowrite got=%h exp=00500093", i0);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp2 [4] = '{32'h11111111, 32'h22222222,
                              32'h33333333, 32'h44444444};
    start();
    put(8'h05);
    put(8'h00);
    for (int w = 1; w <= 5; w++)
      for (int k = 0; k < 4; k++) put(8'(8'h11 * w));
    @(negedge clk);
    checks++;
    if ({h2, d2, e2} !== 3'b011 || w2 !== 16'd5) begin
      failures++;
      $display("FAIL ov_small got=%b/%0d exp=011/5", {h2, d2, e2}, w2);
    end
    checks++;
    if ({h0, d0, e0} !== 3'b010 || w0 !== 16'd5) begin
      failures++;
      $display("FAIL ov_big got=%b/%0d exp=010/5", {h0, d0, e0}, w0);
    end
    for (int a = 0; a < 4; a++) begin
      fa = 14'(a);
      @(negedge clk);
      checks++;
      if (i2 !== exp2[a]) begin
        failures++; $display("FAIL ov_m%0d got=%h exp=%h", a, i2, exp2[a]);
      end
    end
    fa = 14'd4;
    @(negedge clk);
    checks++;
    if (i0 !== 32'h55555555) begin
      failures++; $display("FAIL ov_big_m4 got=%h exp=55555555", i0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s [8] = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                          8'hAA, 8'hBB};
    start();
    foreach (s[i]) put(s[i]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({h0, d0, e0} !== 3'b000 || w0 !== 16'd0) begin
      failures++;
      $display("FAIL rm_flags got=%b/%0d exp=000/0", {h0, d0, e0}, w0);
    end
    put(8'hCC); put(8'hDD); put(8'hEE); put(8'hFF);
    @(negedge clk);
    checks++;
    if (h0 !== 1'b0 || w0 !== 16'd0 || d0 !== 1'b0) begin
      failures++;
      $display("FAIL rm_ignored got=%b%b/%0d exp=00/0", h0, d0, w0);
    end
    fa = 14'd0;
    @(negedge clk);
    checks++;
    if (i0 !== 32'h04030201) begin
      failures++; $display("FAIL rm_m0 got=%h exp=04030201", i0);
    end
    fa = 14'd1;
    @(negedge clk);
    checks++;
    if (i0 !== 32'h22222222) begin
      failures++; $display("FAIL rm_m1 got=%h exp=22222222", i0);
    end
  endtask

  task automatic test_read_first();
    fa = 14'd1;
    start();
    put(8'h02); put(8'h00);
    put(8'h01); put(8'h00); put(8'h00); put(8'h00);
    put(8'h11);
    upg = 1'b1; bv = 1'b1; bd = 8'h22;
    @(negedge clk);
    upg = 1'b0; bv = 1'b0;
    put(8'h33);
    checks++;
    if (i0 !== 32'h22222222) begin
      failures++; $display("FAIL rf_before got=%h exp=22222222", i0);
    end
    put(8'h44);
    checks++;
    if (i0 !== 32'h22222222 || w0 !== 16'd2 || h0 !== 1'b1) begin
      failures++;
      $display("FAIL rf_same got=%h/%0d/%b exp=22222222/2/1", i0, w0, h0);
    end
    @(negedge clk);
    checks++;
    if (i0 !== 32'h44332211 || d0 !== 1'b1 || h0 !== 1'b0) begin
      failures++;
      $display("FAIL rf_next got=%h/%b%b exp=44332211/10", i0, d0, h0);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_fetch_after_reset();
    test_zero_len();
    test_overflow();
    test_reset_mid();
    test_read_first();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_rom_loader.md
Name: prog_rom_loader

Overview:
Instruction-memory side of the fetch interface: a word-addressed program ROM that answers instruction fetches and can be rewritten at run time from a byte stream (UART receiver output). The fetch unit drives the word address (PC[ADDR_W+1:2]) and consumes the instruction word. This block writes the memory, holds the CPU while programming, and releases it when the image is complete.

Parameters:
ADDR_W, 14, word-address width; memory depth = 2**ADDR_W words of 32 bits
LEN_W, 16, width of the word-count header

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  reset, synchronous, active-high
fetch_addr_i  in  ADDR_W  word address from fetch unit (PC>>2)
instruction_o  out  32  registered read data for fetch_addr_i
upg_start_i  in  1  one-cycle pulse: begin programming session
byte_valid_i  in  1  one-cycle strobe, byte_data_i valid
byte_data_i  in  8  received byte
cpu_hold_o  out  1  1 = CPU must be held in reset (session active)
done_o  out  1  sticky: last session completed
err_o  out  1  sticky: last session had overflow
words_written_o  out  LEN_W  words stored in current/last session

Behaviour:
- Reset: state IDLE, cpu_hold_o=0, done_o=0, err_o=0, words_written_o=0, byte counter=0, instruction_o=0. Memory contents are NOT cleared by reset.
- Read path: every rising edge instruction_o <= mem[fetch_addr_i]; 1-cycle latency; reads run in all states.
- Read/write same address same cycle: instruction_o returns old data (read-first).
- States: IDLE, LEN0, LEN1, DATA, DONE.
- IDLE: upg_start_i -> LEN0; same edge set cpu_hold_o=1, clear done_o, err_o, words_written_o, byte counter.
- LEN0: byte_valid_i -> len[7:0]=byte, -> LEN1.
- LEN1: byte_valid_i -> len[15:8]=byte; if assembled len==0 -> DONE, else -> DATA.
- DATA: bytes little-endian, byte k of a word into bits [8k+7:8k], k=0..3 via 2-bit byte counter. On 4th byte: write word to mem[words_written_o[ADDR_W-1:0]] if words_written_o < 2**ADDR_W, else discard and set err_o; increment words_written_o; counter wraps to 0. When words_written_o reaches len -> DONE on that same edge.
- Write occurs on the same edge as the 4th byte strobe; word visible on instruction_o from the next read edge.
- DONE: one cycle; set done_o=1, cpu_hold_o=0, -> IDLE.
- No backpressure: byte_valid_i accepted in any cycle of LEN0/LEN1/DATA, including back-to-back cycles. byte_valid_i in IDLE/DONE ignored.
- upg_start_i outside IDLE ignored (session not restarted).
- upg_start_i and byte_valid_i same cycle in IDLE: start taken, byte ignored.
- reset mid-session: returns to IDLE, cpu_hold_o=0, partial image stays in memory, done_o=0.
- words_written_o saturates at 2**LEN_W-1 (unreachable in practice since len bounds it).

Test Plan:
- Reset then fetch_addr_i=0..3 with preloaded image -> instruction_o matches mem one cycle after each address; cpu_hold_o=0, done_o=0.
- upg_start_i, bytes 02 00, EF BE AD DE, 78 56 34 12 -> mem[0]=0xDEADBEEF, mem[1]=0x12345678, cpu_hold_o high from start edge through DONE, done_o=1, words_written_o=2, err_o=0.
- Header 00 00 -> DONE in the cycle after LEN1, no writes, done_o=1, words_written_o=0.
- ADDR_W=2, header 05 00 plus 20 bytes -> mem[0..3] written, 5th word discarded, err_o=1, words_written_o=5, done_o=1.
- Mid-session after 1 word + 2 bytes, assert reset -> state IDLE, cpu_hold_o=0, mem[0] holds new word, mem[1] unchanged; byte_valid_i afterwards ignored.
- fetch_addr_i=1 held while 4th byte of word 1 arrives -> instruction_o shows old mem[1] that cycle, new value next cycle; upg_start_i pulsed during DATA has no effect.
